// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter among
// NUM_REQ byte requesters, one frame per grant.
// Ports: CLK, RST (async, active high); req/req_data/req_par_en/
//   req_par_type per requester; ack/done one-hot pulses; err watchdog
//   pulse; owner = current/last grant; arb_busy = not IDLE;
//   tx_p_data/tx_data_valid/tx_parity_enable/tx_parity_type to the
//   transmitter; tx_busy from the transmitter.
// Optional: define UART_TX_ARB_WATCHDOG_EN to abandon a launch whose
//   tx_busy never rises within WDOG_CYCLES (err pulse, no done).
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int WDOG_CYCLES = 16,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_par_en,
  input  logic [NUM_REQ-1:0]            req_par_type,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [ID_W-1:0]               owner,
  output logic                          arb_busy,
  output logic [DATA_WIDTH-1:0]         tx_p_data,
  output logic                          tx_data_valid,
  output logic                          tx_parity_enable,
  output logic                          tx_parity_type,
  input  logic                          tx_busy
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_END
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] win;
  logic            found;
  int              idx;

  if (NUM_REQ < 2 || WDOG_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ >= 2 and WDOG_CYCLES >= 1");
  end

  // First asserted request scanning upward from the slot after the
  // last grant, wrapping; this is what makes the rotation fair.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0] wdog_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      last             <= ID_W'(NUM_REQ - 1);
      owner            <= '0;
      ack              <= '0;
      done             <= '0;
      arb_busy         <= 1'b0;
      tx_p_data        <= '0;
      tx_data_valid    <= 1'b0;
      tx_parity_enable <= 1'b0;
      tx_parity_type   <= 1'b0;
`ifdef UART_TX_ARB_WATCHDOG_EN
      err              <= 1'b0;
      wdog_cnt         <= '0;
`endif
    end else begin
      ack           <= '0;
      done          <= '0;
      tx_data_valid <= 1'b0;
`ifdef UART_TX_ARB_WATCHDOG_EN
      err           <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // A busy transmitter here is driven by someone else.
          if (found && !tx_busy) begin
            owner            <= win;
            tx_p_data        <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
            tx_parity_enable <= req_par_en[win];
            tx_parity_type   <= req_par_type[win];
            tx_data_valid    <= 1'b1;
            ack              <= NUM_REQ'(1) << win;
            arb_busy         <= 1'b1;
            state            <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef UART_TX_ARB_WATCHDOG_EN
          wdog_cnt <= '0;
`endif
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_busy) begin
            state <= WAIT_END;
          end
`ifdef UART_TX_ARB_WATCHDOG_EN
          else if (wdog_cnt == CNT_W'(WDOG_CYCLES - 1)) begin
            err      <= 1'b1;
            last     <= owner;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + CNT_W'(1);
          end
`endif
        end
        WAIT_END: begin
          if (!tx_busy) begin
            done     <= NUM_REQ'(1) << owner;
            last     <= owner;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized self-checking bench for uart_tx_arbiter
// against a queue-free round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_par_en;
  logic [N-1:0]    req_par_type;
  logic [N-1:0]    ack;
  logic [N-1:0]    done;
  logic            err;
  logic [1:0]      owner;
  logic            arb_busy;
  logic [DW-1:0]   tx_p_data;
  logic            tx_data_valid;
  logic            tx_parity_enable;
  logic            tx_parity_type;
  logic            tx_busy;

  int checks = 0;
  int errors = 0;
  int last_grant = N - 1;

  uart_tx_arbiter dut (
    .CLK(CLK),
    .RST(RST),
    .req(req),
    .req_data(req_data),
    .req_par_en(req_par_en),
    .req_par_type(req_par_type),
    .ack(ack),
    .done(done),
    .err(err),
    .owner(owner),
    .arb_busy(arb_busy),
    .tx_p_data(tx_p_data),
    .tx_data_valid(tx_data_valid),
    .tx_parity_enable(tx_parity_enable),
    .tx_parity_type(tx_parity_type),
    .tx_busy(tx_busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last_grant + k) % N]) return (last_grant + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic randomize_payload;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    req_par_en   = N'($urandom);
    req_par_type = N'($urandom);
  endtask

  task automatic apply_reset;
    RST = 1'b1;
    req = '0;
    tx_busy = 1'b0;
    tick;
    tick;
    RST = 1'b0;
    last_grant = N - 1;
    tick;
  endtask

  task automatic run_frame(input logic [N-1:0] r, input bit hold,
                           input int busy_len);
    int e;
    logic [DW-1:0] ed;
    e = model_pick(r);
    if (e < 0) return;
    ed = req_data[e*DW +: DW];
    req = r;
    tick;
    checks++;
    if (ack !== onehot(e) || tx_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL grant_ack: ack=%b dv=%b required ack=%b dv=1",
               ack, tx_data_valid, onehot(e));
    end
    checks++;
    if (owner !== 2'(e) || tx_p_data !== ed ||
        tx_parity_enable !== req_par_en[e] ||
        tx_parity_type !== req_par_type[e]) begin
      errors++;
      $display("FAIL grant_payload: own=%0d d=%h pe=%b pt=%b required %0d %h %b %b",
               owner, tx_p_data, tx_parity_enable, tx_parity_type,
               e, ed, req_par_en[e], req_par_type[e]);
    end
    if (!hold) req = '0;
    tick;
    checks++;
    if (tx_data_valid !== 1'b0 || ack !== '0 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse: dv=%b ack=%b busy=%b required 0 0000 1",
               tx_data_valid, ack, arb_busy);
    end
    tx_busy = 1'b1;
    tick;
    repeat (busy_len) tick;
    checks++;
    if (done !== '0 || tx_p_data !== ed) begin
      errors++;
      $display("FAIL hold_frame: done=%b d=%h required 0000 %h",
               done, tx_p_data, ed);
    end
    tx_busy = 1'b0;
    tick;
    checks++;
    if (done !== onehot(e) || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_done: done=%b busy=%b required %b 0",
               done, arb_busy, onehot(e));
    end
    last_grant = e;
  endtask

  task automatic test_reset;
    req_par_en = '0;
    req_par_type = '0;
    req_data = '0;
    apply_reset;
    checks++;
    if ({ack, done, err, owner, arb_busy, tx_p_data, tx_data_valid,
         tx_parity_enable, tx_parity_type} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b done=%b err=%b own=%0d busy=%b d=%h required all 0",
               ack, done, err, owner, arb_busy, tx_p_data);
    end
  endtask

  task automatic test_single;
    randomize_payload;
    req_data[7:0] = 8'hA5;
    req_par_en[0] = 1'b1;
    req_par_type[0] = 1'b0;
    run_frame(4'b0001, 1'b0, 3);
  endtask

  task automatic test_round_robin;
    apply_reset;
    randomize_payload;
    for (int k = 0; k < 5; k++) begin
      run_frame(4'b1111, 1'b1, int'($urandom_range(0, 4)));
      checks++;
      if (owner !== 2'(k % N)) begin
        errors++;
        $display("FAIL rr_order: owner=%0d required %0d", owner, k % N);
      end
    end
    req = '0;
    tick;
  endtask

  task automatic test_skip_wrap;
    randomize_payload;
    run_frame(4'b0100, 1'b0, 1);
    run_frame(4'b0011, 1'b0, 2);
    run_frame(4'b0011, 1'b0, 2);
  endtask

  task automatic test_busy_interlock;
    int quiet;
    randomize_payload;
    tx_busy = 1'b1;
    req = 4'b0100;
    quiet = 1;
    repeat (4) begin
      tick;
      if (ack !== '0 || tx_data_valid !== 1'b0) quiet = 0;
    end
    checks++;
    if (quiet != 1) begin
      errors++;
      $display("FAIL interlock_hold: ack=%b dv=%b required no grant",
               ack, tx_data_valid);
    end
    tx_busy = 1'b0;
    tick;
    checks++;
    if (ack !== 4'b0100 || tx_p_data !== req_data[2*DW +: DW]) begin
      errors++;
      $display("FAIL interlock_release: ack=%b d=%h required 0100 %h",
               ack, tx_p_data, req_data[2*DW +: DW]);
    end
    req = '0;
    tick;
    tx_busy = 1'b1;
    tick;
    tx_busy = 1'b0;
    tick;
    checks++;
    if (done !== 4'b0100) begin
      errors++;
      $display("FAIL interlock_done: done=%b required 0100", done);
    end
    last_grant = 2;
  endtask

  task automatic test_idle_noise;
    tx_busy = 1'b1;
    tick;
    tx_busy = 1'b0;
    req = 4'b0001;
    #2;
    req = '0;
    tick;
    tick;
    checks++;
    if (arb_busy !== 1'b0 || ack !== '0 || done !== '0) begin
      errors++;
      $display("FAIL idle_noise: busy=%b ack=%b done=%b required 0 0000 0000",
               arb_busy, ack, done);
    end
  endtask

  task automatic test_watchdog;
    int e;
    int seen_err;
    int seen_done;
    int at;
    randomize_payload;
    e = model_pick(4'b1000);
    req = 4'b1000;
    tick;
    req = '0;
    seen_err = 0;
    seen_done = 0;
    at = 0;
    for (int c = 1; c <= 24; c++) begin
      tick;
      if (err === 1'b1 && seen_err == 0) at = c;
      if (err === 1'b1) seen_err++;
      if (done !== '0) seen_done++;
    end
`ifdef UART_TX_ARB_WATCHDOG_EN
    checks++;
    if (seen_err != 1 || at != 17 || seen_done != 0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL watchdog: errs=%0d at=%0d dones=%0d busy=%b required 1 17 0 0",
               seen_err, at, seen_done, arb_busy);
    end
    last_grant = e;
`else
    checks++;
    if (seen_err != 0 || seen_done != 0 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL no_watchdog: errs=%0d dones=%0d busy=%b required 0 0 1",
               seen_err, seen_done, arb_busy);
    end
    tx_busy = 1'b1;
    tick;
    tx_busy = 1'b0;
    tick;
    checks++;
    if (done !== onehot(e)) begin
      errors++;
      $display("FAIL late_start_done: done=%b required %b", done, onehot(e));
    end
    last_grant = e;
`endif
  endtask

  task automatic test_reset_midframe;
    randomize_payload;
    req = 4'b0100;
    tick;
    req = '0;
    tick;
    tx_busy = 1'b1;
    tick;
    tick;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++;
    if ({ack, done, owner, arb_busy, tx_p_data, tx_data_valid,
         tx_parity_enable, tx_parity_type} !== '0) begin
      errors++;
      $display("FAIL async_reset: ack=%b done=%b own=%0d busy=%b d=%h required all 0",
               ack, done, owner, arb_busy, tx_p_data);
    end
    tx_busy = 1'b0;
    tick;
    RST = 1'b0;
    last_grant = N - 1;
    tick;
    checks++;
    if (done !== '0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done=%b busy=%b required 0000 0",
               done, arb_busy);
    end
    run_frame(4'b0010, 1'b0, 2);
  endtask

  task automatic test_random;
    for (int k = 0; k < 24; k++) begin
      randomize_payload;
      run_frame(N'($urandom_range(1, 15)), 1'b0,
                int'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    RST = 1'b1;
    req = '0;
    tx_busy = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_skip_wrap;
    test_busy_interlock;
    test_idle_noise;
    test_watchdog;
    test_reset_midframe;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
